// File: rtl/flash_read_cache.sv
// Direct-mapped, one-word-per-line read cache in front of the SPI flash reader.
// Hits answer in one cycle. A miss issues a single-word flash read, then fills
// the line when the flash data comes back.
module flash_read_cache #(
    parameter int LINES  = 64,
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rstrb,
    input  logic [ADDR_W-1:0] word_address,
    output logic [31:0]       rdata,
    output logic              rbusy,
    input  logic              invalidate,
    output logic              f_rstrb,
    output logic [ADDR_W-1:0] f_word_address,
    input  logic [31:0]       f_rdata,
    input  logic              f_rbusy,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
);
    localparam int IW = $clog2(LINES);
    localparam int TW = ADDR_W - IW;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rbusy_q, rbusy_d;
    // Cleared by an invalidate that lands while a fill is in flight, so the
    // returning word reaches the CPU but the line stays invalid.
    logic              fill_ok_q, fill_ok_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [15:0]       hit_q, hit_d, miss_q, miss_d;

    logic [TW-1:0]     tag_mem  [LINES];
    logic [31:0]       data_mem [LINES];

    logic [IW-1:0]     rd_idx, fill_idx;
    logic [TW-1:0]     rd_tag;
    logic              hit, fill_we;

    assign rd_idx   = word_address[IW-1:0];
    assign rd_tag   = word_address[ADDR_W-1:IW];
    assign fill_idx = addr_q[IW-1:0];
    // invalidate in the same cycle as the strobe forces a miss
    assign hit      = valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag) && !invalidate;

    assign rdata          = rdata_q;
    assign rbusy          = rbusy_q;
    assign f_rstrb        = (state_q == REQ);
    assign f_word_address = addr_q;
    assign hit_count      = hit_q;
    assign miss_count     = miss_q;

    // Next-state, lookup, fill and counter logic
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rdata_d   = rdata_q;
        rbusy_d   = rbusy_q;
        fill_ok_d = fill_ok_q;
        valid_d   = valid_q;
        hit_d     = hit_q;
        miss_d    = miss_q;
        fill_we   = 1'b0;

        if (invalidate) valid_d = '0;

        case (state_q)
            IDLE: begin
                if (rstrb) begin
                    if (hit) begin
                        rdata_d = data_mem[rd_idx];
                        if (hit_q != 16'hFFFF) hit_d = hit_q + 16'd1;
                    end else begin
                        addr_d    = word_address;
                        rbusy_d   = 1'b1;
                        fill_ok_d = 1'b1;
                        if (miss_q != 16'hFFFF) miss_d = miss_q + 16'd1;
                        state_d   = REQ;
                    end
                end
            end
            REQ: begin
                if (invalidate) fill_ok_d = 1'b0;
                state_d = WAIT;
            end
            WAIT: begin
                if (invalidate) fill_ok_d = 1'b0;
                if (!f_rbusy) begin
                    rdata_d = f_rdata;
                    fill_we = 1'b1;
                    if (fill_ok_q && !invalidate) valid_d[fill_idx] = 1'b1;
                    rbusy_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and valid bits; reset drops any fill in flight
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rdata_q   <= '0;
            rbusy_q   <= 1'b0;
            fill_ok_q <= 1'b0;
            valid_q   <= '0;
            hit_q     <= '0;
            miss_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rdata_q   <= rdata_d;
            rbusy_q   <= rbusy_d;
            fill_ok_q <= fill_ok_d;
            valid_q   <= valid_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
        end
    end

    // Tag/data storage, no reset so it can map to RAM; valid bits guard it
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_mem[fill_idx]  <= addr_q[ADDR_W-1:IW];
            data_mem[fill_idx] <= f_rdata;
        end
    end
endmodule

// File: tb/tb_flash_read_cache.sv
// Bench for flash_read_cache: directed table, mid-fill corner cases,
// randomized reads against a line-level cache model, counter saturation.
module tb_flash_read_cache;
    localparam int LINES = 64;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        rstrb = 1'b0;
    logic [19:0] word_address = '0;
    logic [31:0] rdata;
    logic        rbusy;
    logic        invalidate = 1'b0;
    logic        f_rstrb;
    logic [19:0] f_word_address;
    logic [31:0] f_rdata = '0;
    logic        f_rbusy = 1'b0;
    logic [15:0] hit_count, miss_count;

    int checks = 0;
    int errors = 0;
    int lat = 20;

    flash_read_cache #(.LINES(LINES), .ADDR_W(20)) dut (
        .clk(clk), .resetn(resetn), .rstrb(rstrb), .word_address(word_address),
        .rdata(rdata), .rbusy(rbusy), .invalidate(invalidate),
        .f_rstrb(f_rstrb), .f_word_address(f_word_address),
        .f_rdata(f_rdata), .f_rbusy(f_rbusy),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // flash contents
    function automatic logic [31:0] flash_fn(input logic [19:0] a);
        if (a == 20'h00010) return 32'hDEADBEEF;
        if (a == 20'h00050) return 32'h12345678;
        return ({12'h0, a} * 32'h9E3779B1) + 32'h01234567;
    endfunction

    // flash reader: busy the cycle after f_rstrb, data ready lat cycles after it
    int          fcnt = 0;
    logic [31:0] fpend = '0;
    always @(posedge clk) begin
        if (f_rstrb) begin
            fcnt  <= lat - 1;
            fpend <= flash_fn(f_word_address);
            if (lat <= 1) begin
                f_rbusy <= 1'b0;
                f_rdata <= flash_fn(f_word_address);
            end else begin
                f_rbusy <= 1'b1;
                f_rdata <= 32'hBAD0BAD0;
            end
        end else if (fcnt > 1) begin
            fcnt <= fcnt - 1;
        end else if (fcnt == 1) begin
            fcnt    <= 0;
            f_rbusy <= 1'b0;
            f_rdata <= fpend;
        end
    end

    // reference model: which address each line holds, plus event counts
    bit   m_valid [LINES];
    int   m_tag   [LINES];
    int   m_hit, m_miss;

    function automatic logic [15:0] sat(input int n);
        return (n > 65535) ? 16'hFFFF : n[15:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) m_valid[i] = 0;
        m_hit = 0;
        m_miss = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rdata"}, rdata, 0);
        check({tag, "_rbusy"}, {31'b0, rbusy}, 0);
        check({tag, "_f_rstrb"}, {31'b0, f_rstrb}, 0);
        check({tag, "_f_addr"}, {12'b0, f_word_address}, 0);
        check({tag, "_hits"}, {16'b0, hit_count}, 0);
        check({tag, "_misses"}, {16'b0, miss_count}, 0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_vals("reset");
        model_reset();
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    // One CPU read. inv_mode: 1 invalidate pulse before, 2 invalidate with the
    // strobe. mid: 1 invalidate during WAIT, 2 reset during WAIT.
    // exp_hit: -1 takes the expectation from the model.
    task automatic do_read(input logic [19:0] a, input int inv_mode, input int mid, input int exp_hit);
        int  idx, tg, busy_cycles, pulses;
        bit  eh, ok_fill;
        idx = int'(a[5:0]);
        tg  = int'(a[19:6]);
        if (inv_mode == 1) begin
            invalidate = 1'b1;
            @(posedge clk); #1 invalidate = 1'b0;
        end
        if (inv_mode != 0) for (int i = 0; i < LINES; i++) m_valid[i] = 0;
        eh = (exp_hit >= 0) ? (exp_hit != 0) : (m_valid[idx] && m_tag[idx] == tg);
        rstrb = 1'b1;
        word_address = a;
        invalidate = (inv_mode == 2);
        @(posedge clk); #1 rstrb = 1'b0; invalidate = 1'b0;
        if (eh) begin
            m_hit++;
            check("hit_rbusy", {31'b0, rbusy}, 0);
            check("hit_f_rstrb", {31'b0, f_rstrb}, 0);
            check("hit_rdata", rdata, flash_fn(a));
        end else begin
            m_miss++;
            ok_fill = 1;
            busy_cycles = 0;
            pulses = 0;
            check("miss_rbusy_rise", {31'b0, rbusy}, 1);
            for (int k = 0; k < 1000; k++) begin
                if (!rbusy) break;
                busy_cycles++;
                if (f_rstrb) begin
                    pulses++;
                    check("miss_f_addr", {12'b0, f_word_address}, {12'b0, a});
                end
                if (mid == 1 && k == 3) begin
                    invalidate = 1'b1;
                    ok_fill = 0;
                    for (int i = 0; i < LINES; i++) m_valid[i] = 0;
                end
                if (mid == 2 && k == 3) begin
                    resetn = 1'b0;
                    #1 check_reset_vals("midfill_reset");
                    model_reset();
                    resetn = 1'b1;
                    return;
                end
                @(posedge clk); #1 invalidate = 1'b0;
            end
            check("miss_busy_cycles", busy_cycles, lat + 1);
            check("miss_f_pulses", pulses, 1);
            check("miss_rdata", rdata, flash_fn(a));
            m_tag[idx]   = tg;
            m_valid[idx] = ok_fill;
        end
        check("hit_count", {16'b0, hit_count}, {16'b0, sat(m_hit)});
        check("miss_count", {16'b0, miss_count}, {16'b0, sat(m_miss)});
    endtask

    typedef struct {
        logic [19:0] addr;
        int          inv_mode;
        int          mid;
        int          exp_hit;
    } vec_t;

    vec_t        tbl [14];
    logic [19:0] pool [8];

    initial begin
        tbl[0]  = '{20'h00010, 0, 0, 0};  // cold miss
        tbl[1]  = '{20'h00010, 0, 0, 1};  // hit
        tbl[2]  = '{20'h00050, 0, 0, 0};  // same index, evicts 0x10
        tbl[3]  = '{20'h00010, 0, 0, 0};  // evicted -> miss
        tbl[4]  = '{20'h00010, 0, 0, 1};
        tbl[5]  = '{20'h00050, 1, 0, 0};  // invalidate pulse, then miss
        tbl[6]  = '{20'h00050, 0, 0, 1};
        tbl[7]  = '{20'h00050, 2, 0, 0};  // invalidate with strobe wins
        tbl[8]  = '{20'h00090, 0, 1, 0};  // invalidate during WAIT
        tbl[9]  = '{20'h00090, 0, 0, 0};  // fill left line invalid
        tbl[10] = '{20'h00090, 0, 0, 1};
        tbl[11] = '{20'h00123, 0, 2, 0};  // reset during WAIT
        tbl[12] = '{20'h00123, 0, 0, 0};
        tbl[13] = '{20'h00090, 0, 0, 0};  // reset cleared everything

        pool = '{20'h00010, 20'h00050, 20'h00090, 20'h00011,
                 20'h0003F, 20'hFFFFF, 20'hFFFD0, 20'h00051};

        model_reset();
        do_reset();

        lat = 20;
        for (int i = 0; i < 14; i++)
            do_read(tbl[i].addr, tbl[i].inv_mode, tbl[i].mid, tbl[i].exp_hit);

        // randomized reads, model decides hit/miss
        for (int i = 0; i < 300; i++) begin
            int          im, r;
            logic [19:0] a;
            lat = int'($urandom_range(1, 6));
            r   = int'($urandom_range(0, 9));
            a   = (r == 0) ? 20'($urandom) : pool[$urandom_range(0, 7)];
            r   = int'($urandom_range(0, 19));
            im  = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            do_read(a, im, 0, -1);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        // saturation: one miss, then back-to-back hits past 0xFFFF
        do_reset();
        lat = 3;
        do_read(20'h00010, 0, 0, 0);
        begin
            int bad = 0;
            rstrb = 1'b1;
            word_address = 20'h00010;
            for (int i = 0; i < 65540; i++) begin
                @(posedge clk); #1;
                if (rbusy || f_rstrb) bad++;
            end
            rstrb = 1'b0;
            @(posedge clk); #1;
            check("sat_no_flash", bad, 0);
            check("sat_hits", {16'b0, hit_count}, 32'h0000FFFF);
            check("sat_misses", {16'b0, miss_count}, 1);
            check("sat_rdata", rdata, 32'hDEADBEEF);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
